// File: rtl/pulse_ctrl_pkg.sv
// Shared definitions for the pulse instruction path: word geometry, pack FSM
// state encoding and the opcode field position used by bench and software models.
package pulse_ctrl_pkg;

    localparam int INST_WIDTH = 64;
    localparam int HALF_WIDTH = 32;

    localparam int OPCODE_MSB = 63;
    localparam int OPCODE_LSB = 60;

    typedef logic [1:0] pack_state_t;

    localparam pack_state_t ST_LOW  = 2'd0;
    localparam pack_state_t ST_HIGH = 2'd1;
    localparam pack_state_t ST_PUSH = 2'd2;

endpackage

// File: rtl/release_generator.sv
// One-shot release to the timing controller: fires once on FIFO fill, flush or
// prolonged bus idle after a push, then stays quiet until init.
module release_generator #(
    parameter int IDLE_RELEASE_CYCLES = 1000,
    parameter int IDLE_TIMER_WIDTH    = 24
) (
    input  logic clock,
    input  logic resetn,
    input  logic init,
    input  logic in_low,
    input  logic in_push,
    input  logic fifo_full,
    input  logic flush,
    input  logic handshake,
    input  logic push,
    output logic release_pulse
);

    localparam logic [IDLE_TIMER_WIDTH-1:0] IDLE_LIMIT = IDLE_TIMER_WIDTH'(IDLE_RELEASE_CYCLES);
    localparam logic [IDLE_TIMER_WIDTH-1:0] IDLE_LAST  =
        (IDLE_RELEASE_CYCLES == 0) ? '0 : IDLE_TIMER_WIDTH'(IDLE_RELEASE_CYCLES - 1);

    logic                        released_q, released_d;
    logic                        pushed_q, pushed_d;
    logic [IDLE_TIMER_WIDTH-1:0] timer_q, timer_d;
    logic                        idle, ev_fill, ev_idle, fire;

    // The idle event looks one count ahead so the pulse lands on the Nth idle cycle itself.
    assign idle    = in_low & ~handshake;
    assign ev_fill = in_push & fifo_full;
    assign ev_idle = (IDLE_RELEASE_CYCLES != 0) & pushed_q & idle & (timer_q >= IDLE_LAST);
    assign fire    = (ev_fill | flush | ev_idle) & ~released_q & ~init;

    assign release_pulse = fire & resetn;

    always_comb begin
        timer_d    = timer_q;
        released_d = released_q | fire;
        pushed_d   = pushed_q | push;
        if (init) begin
            timer_d    = '0;
            released_d = 1'b0;
            pushed_d   = 1'b0;
        end else if (!idle) begin
            timer_d = '0;
        end else if (timer_q < IDLE_LIMIT) begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            timer_q    <= '0;
            released_q <= 1'b0;
            pushed_q   <= 1'b0;
        end else begin
            timer_q    <= timer_d;
            released_q <= released_d;
            pushed_q   <= pushed_d;
        end
    end

endmodule

// File: rtl/inst_fifo_writer.sv
// Packs pairs of 32-bit bus writes into 64-bit instruction FIFO words (first
// half in the upper bits), holding a finished word while the FIFO is full.
module inst_fifo_writer
    import pulse_ctrl_pkg::*;
#(
    parameter int BUS_DATA_WIDTH      = 32,
    parameter int IDLE_RELEASE_CYCLES = 1000,
    parameter int IDLE_TIMER_WIDTH    = 24
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic                      init,
    input  logic                      bus_wr_valid,
    input  logic [BUS_DATA_WIDTH-1:0] bus_wr_data,
    output logic                      bus_wr_ready,
    input  logic                      flush,
    input  logic                      inst_fifo_full,
    output logic                      inst_fifo_wr_en,
    output logic [INST_WIDTH-1:0]     inst_fifo_wr_data,
    output logic                      pulse_controller_release,
    output logic                      half_pending,
    output logic [31:0]               dbg_push_count,
    output logic [31:0]               dbg_stall_cycles
);

    pack_state_t                state_q, state_d;
    logic [BUS_DATA_WIDTH-1:0]  half_q, half_d;
    logic [INST_WIDTH-1:0]      word_q, word_d;
    logic [31:0]                push_cnt_q, push_cnt_d;
    logic [31:0]                stall_q, stall_d;
    logic                       handshake, push, stall;

    // Ready is forced low while reset is asserted so the bus sees no acceptance.
    assign bus_wr_ready = resetn & ((state_q != ST_PUSH) | ~inst_fifo_full);
    assign handshake    = bus_wr_valid & bus_wr_ready;
    assign push         = (state_q == ST_PUSH) & ~inst_fifo_full & ~init;
    assign stall        = (state_q == ST_PUSH) & inst_fifo_full;

    assign inst_fifo_wr_en   = push;
    assign inst_fifo_wr_data = word_q;
    assign half_pending      = (state_q == ST_HIGH);
    assign dbg_push_count    = push_cnt_q;
    assign dbg_stall_cycles  = stall_q;

    // half_q doubles as the staging register, so word_q is untouched during a push.
    always_comb begin
        state_d    = state_q;
        half_d     = half_q;
        word_d     = word_q;
        push_cnt_d = push_cnt_q + (push ? 32'd1 : 32'd0);
        stall_d    = stall_q + (stall ? 32'd1 : 32'd0);
        if (init) begin
            state_d    = ST_LOW;
            half_d     = '0;
            word_d     = '0;
            push_cnt_d = '0;
            stall_d    = '0;
        end else begin
            case (state_q)
                ST_LOW: begin
                    if (handshake) begin
                        half_d  = bus_wr_data;
                        state_d = ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (handshake) begin
                        word_d  = {half_q, bus_wr_data};
                        state_d = ST_PUSH;
                    end
                end
                ST_PUSH: begin
                    if (!inst_fifo_full) begin
                        state_d = handshake ? ST_HIGH : ST_LOW;
                        if (handshake) begin
                            half_d = bus_wr_data;
                        end
                    end
                end
                default: state_d = ST_LOW;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_LOW;
            half_q     <= '0;
            word_q     <= '0;
            push_cnt_q <= '0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            half_q     <= half_d;
            word_q     <= word_d;
            push_cnt_q <= push_cnt_d;
            stall_q    <= stall_d;
        end
    end

    release_generator #(
        .IDLE_RELEASE_CYCLES(IDLE_RELEASE_CYCLES),
        .IDLE_TIMER_WIDTH   (IDLE_TIMER_WIDTH)
    ) u_release (
        .clock        (clock),
        .resetn       (resetn),
        .init         (init),
        .in_low       (state_q == ST_LOW),
        .in_push      (state_q == ST_PUSH),
        .fifo_full    (inst_fifo_full),
        .flush        (flush),
        .handshake    (handshake),
        .push         (push),
        .release_pulse(pulse_controller_release)
    );

endmodule

// File: tb/tb_inst_fifo_writer.sv
// Bench for inst_fifo_writer: directed scenarios plus random traffic, all checked
// against a queue-of-accepted-halves reference model.
module tb_inst_fifo_writer;
    import pulse_ctrl_pkg::*;

    localparam int IRC = 10;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        init = 1'b0;
    logic        bus_wr_valid = 1'b0;
    logic [31:0] bus_wr_data = '0;
    logic        flush = 1'b0;
    logic        inst_fifo_full = 1'b0;
    logic        bus_wr_ready;
    logic        inst_fifo_wr_en;
    logic [63:0] inst_fifo_wr_data;
    logic        pulse_controller_release;
    logic        half_pending;
    logic [31:0] dbg_push_count;
    logic [31:0] dbg_stall_cycles;

    inst_fifo_writer #(
        .BUS_DATA_WIDTH     (32),
        .IDLE_RELEASE_CYCLES(IRC),
        .IDLE_TIMER_WIDTH   (24)
    ) dut (
        .clock                   (clock),
        .resetn                  (resetn),
        .init                    (init),
        .bus_wr_valid            (bus_wr_valid),
        .bus_wr_data             (bus_wr_data),
        .bus_wr_ready            (bus_wr_ready),
        .flush                   (flush),
        .inst_fifo_full          (inst_fifo_full),
        .inst_fifo_wr_en         (inst_fifo_wr_en),
        .inst_fifo_wr_data       (inst_fifo_wr_data),
        .pulse_controller_release(pulse_controller_release),
        .half_pending            (half_pending),
        .dbg_push_count          (dbg_push_count),
        .dbg_stall_cycles        (dbg_stall_cycles)
    );

    always #5 clock = ~clock;

    int checkCount = 0;
    int failCount  = 0;
    int relSeen    = 0;
    int relMark;

    // Reference model: halves accepted but not yet pushed, plus release bookkeeping
    logic [31:0] accQ[$];
    bit          relM;
    bit          pushedM;
    int          idleRun;
    logic [31:0] pushCntM;
    logic [31:0] stallCntM;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic modelClear();
        accQ.delete();
        relM      = 1'b0;
        pushedM   = 1'b0;
        idleRun   = 0;
        pushCntM  = '0;
        stallCntM = '0;
    endtask

    // Drive one cycle of inputs, compare against the model mid-cycle, then advance the model.
    task automatic applyStimulus(input bit v, input logic [31:0] d, input bit f, input bit fl, input bit in);
        bit wordAvail, expWrEn, expReady, expHs, idleNow, expRel;
        bus_wr_valid   = v;
        bus_wr_data    = d;
        inst_fifo_full = f;
        flush          = fl;
        init           = in;
        @(negedge clock);
        wordAvail = (accQ.size() >= 2);
        expWrEn   = wordAvail && !f && !in;
        expReady  = !(wordAvail && f);
        expHs     = v && expReady;
        idleNow   = (accQ.size() == 0) && !expHs;
        expRel    = !in && !relM &&
                    ((wordAvail && f) || fl || (IRC != 0 && pushedM && idleNow && (idleRun + 1 >= IRC)));
        checkOutput("wr_en", 64'(inst_fifo_wr_en), 64'(expWrEn));
        if (expWrEn)
            checkOutput("wr_data", inst_fifo_wr_data, {accQ[0], accQ[1]});
        checkOutput("ready", 64'(bus_wr_ready), 64'(expReady));
        checkOutput("half_pending", 64'(half_pending), 64'(accQ.size() == 1));
        checkOutput("release", 64'(pulse_controller_release), 64'(expRel));
        checkOutput("push_count", 64'(dbg_push_count), 64'(pushCntM));
        checkOutput("stall_cycles", 64'(dbg_stall_cycles), 64'(stallCntM));
        if (pulse_controller_release) relSeen++;
        @(posedge clock);
        if (in) begin
            modelClear();
        end else begin
            if (wordAvail && f) stallCntM++;
            if (expWrEn) begin
                void'(accQ.pop_front());
                void'(accQ.pop_front());
                pushCntM++;
                pushedM = 1'b1;
            end
            if (expHs) accQ.push_back(d);
            if (expRel) relM = 1'b1;
            idleRun = idleNow ? ((idleRun < IRC) ? idleRun + 1 : idleRun) : 0;
        end
        #1;
    endtask

    initial begin
        modelClear();
        #3;
        checkOutput("rst_wr_en", 64'(inst_fifo_wr_en), 64'd0);
        checkOutput("rst_ready", 64'(bus_wr_ready), 64'd0);
        checkOutput("rst_release", 64'(pulse_controller_release), 64'd0);
        checkOutput("rst_pending", 64'(half_pending), 64'd0);
        checkOutput("rst_data", inst_fifo_wr_data, 64'd0);
        checkOutput("rst_counts", {dbg_push_count, dbg_stall_cycles}, 64'd0);
        @(posedge clock);
        #1 resetn = 1'b1;

        // Single word, FIFO not full
        applyStimulus(1, 32'h0000_0010, 0, 0, 0);
        applyStimulus(1, 32'h0006_0000, 0, 0, 0);
        applyStimulus(0, 32'h0, 0, 0, 0);
        checkOutput("t1_word", inst_fifo_wr_data, 64'h00000010_00060000);
        checkOutput("t1_pushes", 64'(dbg_push_count), 64'd1);

        // Back-to-back halves, valid held high
        applyStimulus(0, 32'h0, 0, 0, 1);
        for (int i = 0; i < 8; i++) applyStimulus(1, 32'hA000_0000 + 32'(i), 0, 0, 0);
        applyStimulus(0, 32'h0, 0, 0, 0);
        checkOutput("b2b_pushes", 64'(dbg_push_count), 64'd4);
        checkOutput("b2b_last", inst_fifo_wr_data, 64'hA0000006_A0000007);

        // FIFO full for 5 cycles while a word is held
        applyStimulus(0, 32'h0, 0, 0, 1);
        relMark = relSeen;
        applyStimulus(1, 32'h1111_1111, 0, 0, 0);
        applyStimulus(1, 32'h2222_2222, 0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(1, 32'h3333_3333, 1, 0, 0);
        applyStimulus(0, 32'h0, 0, 0, 0);
        checkOutput("full_stall", 64'(dbg_stall_cycles), 64'd5);
        checkOutput("full_rel_once", 64'(relSeen - relMark), 64'd1);
        checkOutput("full_word", inst_fifo_wr_data, 64'h11111111_22222222);

        // Idle auto-release, then no second pulse before init
        applyStimulus(0, 32'h0, 0, 0, 1);
        relMark = relSeen;
        applyStimulus(1, 32'h4444_0000, 0, 0, 0);
        applyStimulus(1, 32'h0000_4444, 0, 0, 0);
        for (int i = 0; i < 15; i++) applyStimulus(0, 32'h0, 0, 0, 0);
        checkOutput("idle_rel_once", 64'(relSeen - relMark), 64'd1);
        relMark = relSeen;
        applyStimulus(1, 32'h5555_0000, 0, 0, 0);
        applyStimulus(1, 32'h0000_5555, 0, 0, 0);
        for (int i = 0; i < 15; i++) applyStimulus(0, 32'h0, 0, 0, 0);
        checkOutput("idle_rel_again", 64'(relSeen - relMark), 64'd0);

        // init discards a pending low half
        applyStimulus(0, 32'h0, 0, 0, 1);
        applyStimulus(1, 32'hDEAD_BEEF, 0, 0, 0);
        applyStimulus(1, 32'hBAD0_BAD0, 0, 0, 1);
        checkOutput("init_pending", 64'(half_pending), 64'd0);
        checkOutput("init_counts", 64'(dbg_push_count), 64'd0);
        applyStimulus(1, 32'h1234_5678, 0, 0, 0);
        applyStimulus(1, 32'h9ABC_DEF0, 0, 0, 0);
        applyStimulus(0, 32'h0, 0, 0, 0);
        checkOutput("init_word", inst_fifo_wr_data, 64'h12345678_9ABCDEF0);

        // flush and full together give one pulse
        applyStimulus(0, 32'h0, 0, 0, 1);
        relMark = relSeen;
        applyStimulus(1, 32'h7777_0000, 0, 0, 0);
        applyStimulus(1, 32'h0000_7777, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 32'h0, 1, 1, 0);
        checkOutput("flush_full_once", 64'(relSeen - relMark), 64'd1);

        // Asynchronous reset in the middle of a push cycle
        bus_wr_valid   = 1'b1;
        inst_fifo_full = 1'b0;
        flush          = 1'b0;
        #2;
        checkOutput("pre_rst_wr_en", 64'(inst_fifo_wr_en), 64'(accQ.size() >= 2));
        resetn = 1'b0;
        #1;
        checkOutput("async_wr_en", 64'(inst_fifo_wr_en), 64'd0);
        checkOutput("async_ready", 64'(bus_wr_ready), 64'd0);
        checkOutput("async_release", 64'(pulse_controller_release), 64'd0);
        bus_wr_valid = 1'b0;
        modelClear();
        @(posedge clock);
        #1 resetn = 1'b1;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 9) < 6, $urandom(), $urandom_range(0, 9) < 3,
                          $urandom_range(0, 49) == 0, $urandom_range(0, 49) == 0);
        end
        for (int i = 0; i < 3; i++) applyStimulus(0, 32'h0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
